// File: rtl/wave_sequencer_if.sv
// Bundle of the sequencer's key, sine-ROM and DAC-side signals.
// No latency of its own; it only groups wires.
// No backpressure: dac_valid is a one-cycle pulse that the DAC serializer must accept.
interface wave_sequencer_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic [4:0]        key_evt;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;
    logic [DATA_W-1:0] dac_value;
    logic              dac_valid;
    logic [1:0]        wave_sel;
    logic [2:0]        amp_sel;
    logic [31:0]       freq_word;

    // Sequencer side: consumes keys and ROM data, drives ROM address and DAC sample.
    modport master (
        input  key_evt, rom_q,
        output rom_addr, dac_value, dac_valid, wave_sel, amp_sel, freq_word
    );

    // Environment side: key debouncer, sine ROM and DAC serializer.
    modport slave (
        output key_evt, rom_q,
        input  rom_addr, dac_value, dac_valid, wave_sel, amp_sel, freq_word
    );
endinterface

// File: rtl/wave_sequencer.sv
// DDS waveform sequencer: phase accumulator, sine-ROM sequencing or computed waves, amplitude scaling.
// Latency: tick cycle T, ROM address at T+1, capture at T+1+ROM_LAT, dac_valid at T+2+ROM_LAT.
// No backpressure: one sample per tick; key edits land in pending registers and apply at the next tick.
module wave_sequencer #(
    parameter int          SAMPLE_DIV = 500,
    parameter int          ROM_LAT    = 2,
    parameter int          ADDR_W     = 11,
    parameter int          DATA_W     = 8,
    parameter logic [31:0] FW_STEP    = 32'd42949673,
    parameter logic [31:0] FW_MAX     = 32'd858993460
) (
    input  logic             clk,
    input  logic             rst,
    wave_sequencer_if.master bus
);

    localparam int CNT_W  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WAIT_W = (ROM_LAT > 2) ? $clog2(ROM_LAT) : 1;
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, CAPT, OUT} state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_tick_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                w_tick;
    logic [31:0]         r_phase, w_phase_nxt;
    logic [31:0]         r_fw, r_fw_pend, w_fw_pend_nxt;
    logic [2:0]          r_amp, r_amp_pend, w_amp_pend_nxt;
    logic [1:0]          r_wave, r_wave_pend, w_wave_pend_nxt;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [DATA_W-1:0]   r_dac;
    logic [DATA_W-1:0]   w_p, w_p2, w_raw, w_scaled;
    logic signed [DATA_W:0]   w_s;
    logic signed [4:0]        w_gain;
    logic signed [DATA_W+3:0] w_prod;
    logic                w_up, w_down, w_left, w_right, w_enter;

    assign {w_enter, w_right, w_left, w_down, w_up} = bus.key_evt;

    assign w_tick      = (r_tick_cnt == CNT_W'(SAMPLE_DIV - 1));
    assign w_phase_nxt = r_phase + r_fw_pend;

    // Free-running sample-rate divider.
    always_ff @(posedge clk) begin
        if (rst || w_tick) r_tick_cnt <= '0;
        else               r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end

    // Pending settings follow key events every cycle, saturating at their limits.
    always_comb begin
        w_fw_pend_nxt   = r_fw_pend;
        w_amp_pend_nxt  = r_amp_pend;
        w_wave_pend_nxt = r_wave_pend;
        if (w_up && !w_down)
            w_fw_pend_nxt = (r_fw_pend >= FW_MAX - FW_STEP) ? FW_MAX : r_fw_pend + FW_STEP;
        else if (w_down && !w_up)
            w_fw_pend_nxt = (r_fw_pend < (FW_STEP << 1)) ? FW_STEP : r_fw_pend - FW_STEP;
        if (w_right && !w_left)
            w_amp_pend_nxt = (r_amp_pend == 3'd7) ? 3'd7 : r_amp_pend + 3'd1;
        else if (w_left && !w_right)
            w_amp_pend_nxt = (r_amp_pend == 3'd0) ? 3'd0 : r_amp_pend - 3'd1;
        if (w_enter)
            w_wave_pend_nxt = r_wave_pend + 2'd1;
    end

    // Pending registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fw_pend   <= FW_STEP;
            r_amp_pend  <= 3'd7;
            r_wave_pend <= 2'd0;
        end else begin
            r_fw_pend   <= w_fw_pend_nxt;
            r_amp_pend  <= w_amp_pend_nxt;
            r_wave_pend <= w_wave_pend_nxt;
        end
    end

    // On tick adopt pending settings and step the phase; the ROM address is
    // issued on the same edge so the ADDR cycle already presents it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fw       <= FW_STEP;
            r_amp      <= 3'd7;
            r_wave     <= 2'd0;
            r_phase    <= '0;
            r_rom_addr <= '0;
        end else if (w_tick) begin
            r_fw       <= r_fw_pend;
            r_amp      <= r_amp_pend;
            r_wave     <= r_wave_pend;
            r_phase    <= w_phase_nxt;
            r_rom_addr <= w_phase_nxt[31 -: ADDR_W];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state; computed waves also pass through WAIT to keep latency uniform.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_tick) w_state_nxt = ADDR;
            ADDR:    w_state_nxt = (ROM_LAT > 1) ? WAIT : CAPT;
            WAIT:    if (r_wait_cnt == WAIT_W'(ROM_LAT - 2)) w_state_nxt = CAPT;
            CAPT:    w_state_nxt = OUT;
            OUT:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counts the ROM_LAT-1 cycles spent in WAIT.
    always_ff @(posedge clk) begin
        if (rst || r_state != WAIT) r_wait_cnt <= '0;
        else                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end

    assign w_p  = r_phase[31 -: DATA_W];
    assign w_p2 = {w_p[DATA_W-2:0], 1'b0};

    // Raw sample selection for the active waveform.
    always_comb begin
        w_raw = bus.rom_q;
        case (r_wave)
            2'd0: w_raw = bus.rom_q;
            2'd1: w_raw = w_p[DATA_W-1] ? '0 : '1;
            2'd2: w_raw = w_p[DATA_W-1] ? ~w_p2 : w_p2;
            2'd3: w_raw = w_p;
            default: w_raw = bus.rom_q;
        endcase
    end

    // Amplitude scaling around midscale: (raw-mid)*(amp+1)/8 with arithmetic shift.
    assign w_s      = $signed({1'b0, w_raw}) - $signed({1'b0, MID});
    assign w_gain   = $signed({2'b00, r_amp} + 5'd1);
    assign w_prod   = (DATA_W+4)'(w_s) * (DATA_W+4)'(w_gain);
    assign w_scaled = DATA_W'(w_prod >>> 3) ^ MID;

    // Output sample register, loaded as CAPT ends so value and valid appear together in OUT.
    always_ff @(posedge clk) begin
        if (rst)                  r_dac <= MID;
        else if (r_state == CAPT) r_dac <= w_scaled;
    end

    assign bus.rom_addr  = r_rom_addr;
    assign bus.dac_value = r_dac;
    assign bus.dac_valid = (r_state == OUT);
    assign bus.wave_sel  = r_wave;
    assign bus.amp_sel   = r_amp;
    assign bus.freq_word = r_fw;

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer with SAMPLE_DIV=8 and a 2-cycle ROM returning addr[10:3].
// Cycle 1 is the first cycle after reset release; the first tick falls in cycle 8.
// Keys are driven just after a rising edge and sampled on the next one.
module tb_wave_sequencer;

    localparam int          SD  = 8;
    localparam logic [31:0] FWS = 32'd42949673;
    localparam logic [31:0] FWM = 32'd858993460;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    wave_sequencer_if #(.ADDR_W(11), .DATA_W(8)) bus ();

    wave_sequencer #(
        .SAMPLE_DIV(SD), .ROM_LAT(2), .ADDR_W(11), .DATA_W(8),
        .FW_STEP(FWS), .FW_MAX(FWM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Sine ROM stand-in: two register stages, data = addr[10:3].
    logic [7:0] rom_d1;
    always @(posedge clk) begin
        rom_d1     <= bus.rom_addr[10:3];
        bus.rom_q  <= rom_d1;
    end

    int vec  = 0;
    int errs = 0;
    int cyc  = 0;

    // A sample tick must only ever be seen while the FSM is idle.
    always @(posedge clk) begin
        if (!rst && dut.w_tick && dut.r_state != 3'd0) begin
            errs++;
            $display("FAIL tick_outside_idle state=%0d required=0", dut.r_state);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        bus.key_evt = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_valid(output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.dac_valid) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic press(input logic [4:0] k);
        bus.key_evt = k;
        tick();
        bus.key_evt = '0;
        tick();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic settle();
        repeat (10) tick();
    endtask

    task automatic test_reset();
        bus.key_evt = '0;
        rst = 1'b1;
        tick();
        tick();
        vec++; if (bus.dac_value !== 8'd128) begin errs++; $display("FAIL reset_dac got=%0d exp=128", bus.dac_value); end
        vec++; if (bus.dac_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", bus.dac_valid); end
        vec++; if (bus.rom_addr !== 11'd0) begin errs++; $display("FAIL reset_addr got=%0d exp=0", bus.rom_addr); end
        vec++; if (bus.wave_sel !== 2'd0) begin errs++; $display("FAIL reset_wave got=%0d exp=0", bus.wave_sel); end
        vec++; if (bus.amp_sel !== 3'd7) begin errs++; $display("FAIL reset_amp got=%0d exp=7", bus.amp_sel); end
        vec++; if (bus.freq_word !== FWS) begin errs++; $display("FAIL reset_freq got=%0d exp=%0d", bus.freq_word, FWS); end
        rst = 1'b0;
        cyc = 1;
    endtask

    task automatic test_first_sample();
        int at;
        wait_valid(at);
        vec++; if (at != 12) begin errs++; $display("FAIL first_valid_cycle got=%0d exp=12", at); end
        vec++; if (bus.dac_value !== 8'd2) begin errs++; $display("FAIL first_dac got=%0d exp=2", bus.dac_value); end
        vec++; if (bus.rom_addr !== 11'd20) begin errs++; $display("FAIL first_addr got=%0d exp=20", bus.rom_addr); end
        tick();
        vec++; if (bus.dac_valid !== 1'b0) begin errs++; $display("FAIL valid_pulse_width got=%b exp=0", bus.dac_valid); end
        vec++; if (bus.dac_value !== 8'd2) begin errs++; $display("FAIL dac_hold got=%0d exp=2", bus.dac_value); end
    endtask

    task automatic test_mid_sample_key();
        int at;
        run_to(18);
        bus.key_evt = 5'b10000;
        tick();
        bus.key_evt = '0;
        vec++; if (bus.wave_sel !== 2'd0) begin errs++; $display("FAIL midkey_wave_now got=%0d exp=0", bus.wave_sel); end
        vec++; if (bus.dac_value !== 8'd2) begin errs++; $display("FAIL midkey_dac_now got=%0d exp=2", bus.dac_value); end
        wait_valid(at);
        vec++; if (at != 20) begin errs++; $display("FAIL midkey_valid2 got=%0d exp=20", at); end
        vec++; if (bus.dac_value !== 8'd5) begin errs++; $display("FAIL midkey_dac2 got=%0d exp=5", bus.dac_value); end
        run_to(24);
        vec++; if (bus.wave_sel !== 2'd0) begin errs++; $display("FAIL midkey_wave_pre_tick got=%0d exp=0", bus.wave_sel); end
        tick();
        vec++; if (bus.wave_sel !== 2'd1) begin errs++; $display("FAIL midkey_wave_post_tick got=%0d exp=1", bus.wave_sel); end
        wait_valid(at);
        vec++; if (at != 28) begin errs++; $display("FAIL midkey_valid3 got=%0d exp=28", at); end
        vec++; if (bus.dac_value !== 8'd255) begin errs++; $display("FAIL midkey_dac3 got=%0d exp=255", bus.dac_value); end
    endtask

    task automatic test_mid_reset();
        int at;
        do_reset();
        wait_valid(at);
        vec++; if (bus.dac_value !== 8'd2) begin errs++; $display("FAIL rstmid_pre_dac got=%0d exp=2", bus.dac_value); end
        run_to(18);
        rst = 1'b1;
        tick();
        vec++; if (bus.dac_value !== 8'd128) begin errs++; $display("FAIL rstmid_dac got=%0d exp=128", bus.dac_value); end
        vec++; if (bus.dac_valid !== 1'b0) begin errs++; $display("FAIL rstmid_valid got=%b exp=0", bus.dac_valid); end
        vec++; if (bus.rom_addr !== 11'd0) begin errs++; $display("FAIL rstmid_addr got=%0d exp=0", bus.rom_addr); end
        rst = 1'b0;
        cyc = 1;
        wait_valid(at);
        vec++; if (at != 12) begin errs++; $display("FAIL rstmid_first_valid got=%0d exp=12", at); end
        vec++; if (bus.dac_value !== 8'd2) begin errs++; $display("FAIL rstmid_first_dac got=%0d exp=2", bus.dac_value); end
    endtask

    task automatic test_keys();
        do_reset();
        repeat (25) press(5'b00001);
        settle();
        vec++; if (bus.freq_word !== FWM) begin errs++; $display("FAIL up_saturate got=%0d exp=%0d", bus.freq_word, FWM); end
        repeat (30) press(5'b00010);
        settle();
        vec++; if (bus.freq_word !== FWS) begin errs++; $display("FAIL down_saturate got=%0d exp=%0d", bus.freq_word, FWS); end
        press(5'b00001);
        settle();
        vec++; if (bus.freq_word !== 32'd85899346) begin errs++; $display("FAIL up_one got=%0d exp=85899346", bus.freq_word); end
        press(5'b00011);
        settle();
        vec++; if (bus.freq_word !== 32'd85899346) begin errs++; $display("FAIL up_down_both got=%0d exp=85899346", bus.freq_word); end
        press(5'b01000);
        settle();
        vec++; if (bus.amp_sel !== 3'd7) begin errs++; $display("FAIL right_saturate got=%0d exp=7", bus.amp_sel); end
        press(5'b00100);
        settle();
        vec++; if (bus.amp_sel !== 3'd6) begin errs++; $display("FAIL left_one got=%0d exp=6", bus.amp_sel); end
        press(5'b01100);
        settle();
        vec++; if (bus.amp_sel !== 3'd6) begin errs++; $display("FAIL left_right_both got=%0d exp=6", bus.amp_sel); end
        press(5'b10101);
        settle();
        vec++; if (bus.amp_sel !== 3'd5) begin errs++; $display("FAIL multi_amp got=%0d exp=5", bus.amp_sel); end
        vec++; if (bus.freq_word !== 32'd128849019) begin errs++; $display("FAIL multi_freq got=%0d exp=128849019", bus.freq_word); end
        vec++; if (bus.wave_sel !== 2'd1) begin errs++; $display("FAIL multi_wave got=%0d exp=1", bus.wave_sel); end
    endtask

    task automatic test_saw();
        int at;
        logic [31:0] ph;
        logic [7:0]  ex;
        do_reset();
        repeat (3) press(5'b10000);
        for (int n = 1; n <= 110; n++) begin
            wait_valid(at);
            ph = 32'(n) * FWS;
            ex = ph[31:24];
            vec++;
            if (at < 0 || bus.dac_value !== ex) begin
                errs++;
                $display("FAIL saw_sample n=%0d got=%0d exp=%0d at=%0d", n, bus.dac_value, ex, at);
            end
        end
        vec++; if (bus.wave_sel !== 2'd3) begin errs++; $display("FAIL saw_wave got=%0d exp=3", bus.wave_sel); end
    endtask

    task automatic test_triangle();
        int at;
        logic [31:0] ph;
        logic [7:0]  p, ex;
        do_reset();
        repeat (2) press(5'b10000);
        for (int n = 1; n <= 110; n++) begin
            wait_valid(at);
            ph = 32'(n) * FWS;
            p  = ph[31:24];
            ex = {p[6:0], 1'b0};
            if (p[7]) ex = ~ex;
            vec++;
            if (at < 0 || bus.dac_value !== ex) begin
                errs++;
                $display("FAIL tri_sample n=%0d got=%0d exp=%0d at=%0d", n, bus.dac_value, ex, at);
            end
        end
    endtask

    task automatic test_square_amp0();
        int at;
        logic [31:0] ph;
        logic [7:0]  ex;
        do_reset();
        bus.key_evt = 5'b10100;
        tick();
        repeat (6) begin
            bus.key_evt = 5'b00100;
            tick();
        end
        bus.key_evt = '0;
        for (int n = 1; n <= 60; n++) begin
            wait_valid(at);
            ph = 32'(n) * FWS;
            ex = ph[31] ? 8'd112 : 8'd143;
            vec++;
            if (at < 0 || bus.dac_value !== ex) begin
                errs++;
                $display("FAIL square_sample n=%0d got=%0d exp=%0d at=%0d", n, bus.dac_value, ex, at);
            end
            if (n == 5) press(5'b00100);
        end
        vec++; if (bus.amp_sel !== 3'd0) begin errs++; $display("FAIL square_amp_floor got=%0d exp=0", bus.amp_sel); end
        vec++; if (bus.wave_sel !== 2'd1) begin errs++; $display("FAIL square_wave got=%0d exp=1", bus.wave_sel); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout time=%0t limit=2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_evt = '0;
        test_reset();
        test_first_sample();
        test_mid_sample_key();
        test_mid_reset();
        test_keys();
        test_saw();
        test_triangle();
        test_square_amp0();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
